// File: rtl/rib_xbar.sv
// Registered request/ready crossbar: arbitrates NUM_MASTERS masters onto NUM_SLAVES
// address-decoded slaves, one transaction at a time, with timeout and error response.
module rib_xbar #(
  parameter int                     NUM_MASTERS = 4,
  parameter int                     NUM_SLAVES  = 8,
  parameter int                     ADDR_W      = 32,
  parameter int                     DATA_W      = 32,
  parameter int                     SEL_W       = 4,
  parameter bit                     ARB_RR      = 1'b1,
  parameter int                     TIMEOUT     = 255,
  parameter logic [NUM_MASTERS-1:0] HOLD_MASK   = 4'b1101
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_MASTERS-1:0]              m_req_i,
  input  logic [NUM_MASTERS-1:0]              m_we_i,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  m_addr_i,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]  m_wdata_i,
  output logic [DATA_W-1:0]                   m_rdata_o,
  output logic [NUM_MASTERS-1:0]              m_ready_o,
  output logic                                m_err_o,
  output logic [NUM_SLAVES-1:0]               s_req_o,
  output logic                                s_we_o,
  output logic [ADDR_W-1:0]                   s_addr_o,
  output logic [DATA_W-1:0]                   s_wdata_o,
  input  logic [NUM_SLAVES-1:0][DATA_W-1:0]   s_rdata_i,
  input  logic [NUM_SLAVES-1:0]               s_ready_i,
  output logic                                hold_flag_o
);

  localparam int GNT_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

  // ERR delays an unmapped response by one cycle so it lines up with a zero-wait access.
  typedef enum logic [1:0] {IDLE, ACCESS, ERR, RESP} state_t;

  state_t            state, state_nxt;
  logic [GNT_W-1:0]  grant, ptr, pick;
  logic              any_req;
  logic [SEL_W-1:0]  pick_sel, sel;
  logic              pick_mapped;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              slv_ready;
  logic [DATA_W-1:0] slv_rdata;
  logic              tmo;

  // Round-robin starts the search at ptr; fixed priority always starts at master 0.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    pick    = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = ARB_RR ? (int'(ptr) + i) % NUM_MASTERS : i;
      if (!any_req && m_req_i[GNT_W'(idx)]) begin
        any_req = 1'b1;
        pick    = GNT_W'(idx);
      end
    end
  end

  assign pick_sel    = m_addr_i[pick][ADDR_W-1 -: SEL_W];
  assign pick_mapped = 32'(pick_sel) < 32'(NUM_SLAVES);
  assign sel         = addr_q[ADDR_W-1 -: SEL_W];

  always_comb begin
    slv_ready = 1'b0;
    slv_rdata = '0;
    s_req_o   = '0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      if (sel == SEL_W'(j)) begin
        slv_ready  = s_ready_i[j];
        slv_rdata  = s_rdata_i[j];
        s_req_o[j] = (state == ACCESS);
      end
    end
  end

  assign tmo = (TIMEOUT != 0) && (wait_cnt == TMO_CNT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = pick_mapped ? ACCESS : ERR;
      ACCESS:  if (slv_ready || tmo) state_nxt = RESP;
      ERR:     state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant    <= '0;
      ptr      <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant    <= pick;
          addr_q   <= m_addr_i[pick];
          we_q     <= m_we_i[pick];
          wdata_q  <= m_wdata_i[pick];
          wait_cnt <= '0;
          if (!pick_mapped) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        // A ready in the same cycle the counter expires still completes normally.
        ACCESS: begin
          if (slv_ready) begin
            rdata_q <= slv_rdata;
            err_q   <= 1'b0;
          end else if (tmo) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: ptr <= (grant == GNT_W'(NUM_MASTERS - 1)) ? '0 : grant + 1'b1;
        default: ;
      endcase
    end
  end

  assign m_ready_o = (state == RESP) ? (NUM_MASTERS'(1) << grant) : '0;
  assign m_err_o   = (state == RESP) && err_q;
  assign m_rdata_o = (state == RESP) ? rdata_q : '0;
  assign s_we_o    = (state == ACCESS) && we_q;
  assign s_addr_o  = (state == ACCESS) ? addr_q : '0;
  assign s_wdata_o = (state == ACCESS) ? wdata_q : '0;

  // Gated by rst_n so the hold flag reads 0 while reset is asserted, even with live requests.
  assign hold_flag_o = rst_n &&
                       ((|(m_req_i & HOLD_MASK)) || ((state != IDLE) && HOLD_MASK[grant]));

endmodule

// File: tb/tb_rib_xbar.sv
// Self-checking bench for rib_xbar: directed vector table, randomized transactions
// against a transaction-level model, reset abort, round-robin and fixed-priority sequences.
module tb_rib_xbar;
  localparam int NM = 4, NS = 8, AW = 32, DW = 32, TO = 4;
  localparam logic [NM-1:0] HOLD = 4'b1101;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NM-1:0]          m_req_i, m_we_i, fp_req;
  logic [NM-1:0][AW-1:0]  m_addr_i;
  logic [NM-1:0][DW-1:0]  m_wdata_i;
  logic [DW-1:0]          m_rdata_o, fp_rdata;
  logic [NM-1:0]          m_ready_o, fp_ready;
  logic                   m_err_o, fp_err;
  logic [NS-1:0]          s_req_o, fp_s_req;
  logic                   s_we_o, fp_s_we;
  logic [AW-1:0]          s_addr_o, fp_s_addr;
  logic [DW-1:0]          s_wdata_o, fp_s_wdata;
  logic [NS-1:0][DW-1:0]  s_rdata_i;
  logic [NS-1:0]          s_ready_i;
  logic                   hold_flag_o, fp_hold;

  always #5 clk = ~clk;

  rib_xbar #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .SEL_W(4),
             .ARB_RR(1'b1), .TIMEOUT(TO), .HOLD_MASK(HOLD)) u_dut (
    .clk(clk), .rst_n(rst_n), .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i),
    .m_wdata_i(m_wdata_i), .m_rdata_o(m_rdata_o), .m_ready_o(m_ready_o), .m_err_o(m_err_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata_i), .s_ready_i(s_ready_i), .hold_flag_o(hold_flag_o));

  rib_xbar #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .SEL_W(4),
             .ARB_RR(1'b0), .TIMEOUT(TO), .HOLD_MASK(HOLD)) u_fp (
    .clk(clk), .rst_n(rst_n), .m_req_i(fp_req), .m_we_i(m_we_i), .m_addr_i(m_addr_i),
    .m_wdata_i(m_wdata_i), .m_rdata_o(fp_rdata), .m_ready_o(fp_ready), .m_err_o(fp_err),
    .s_req_o(fp_s_req), .s_we_o(fp_s_we), .s_addr_o(fp_s_addr), .s_wdata_o(fp_s_wdata),
    .s_rdata_i(s_rdata_i), .s_ready_i(s_ready_i), .hold_flag_o(fp_hold));

  // Master-side view: what each master is presenting while its request is pending.
  logic [AW-1:0] mst_addr  [NM];
  logic          mst_we    [NM];
  logic [DW-1:0] mst_wdata [NM];
  int            ptr_m = 0;
  int            tests = 0, fails = 0;

  typedef struct {
    int          mst;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          wt;
    logic [31:0] srd;
    int          exp_cyc;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_masters();
    for (int i = 0; i < NM; i++) begin
      m_addr_i[i]  = mst_addr[i];
      m_we_i[i]    = mst_we[i];
      m_wdata_i[i] = mst_wdata[i];
    end
  endtask

  task automatic scramble_masters();
    for (int i = 0; i < NM; i++) begin
      m_addr_i[i]  = $urandom;
      m_we_i[i]    = 1'($urandom);
      m_wdata_i[i] = $urandom;
    end
  endtask

  task automatic noise_slaves();
    for (int j = 0; j < NS; j++) s_rdata_i[j] = $urandom;
    s_ready_i = 8'($urandom);
  endtask

  task automatic new_master(input int i);
    int nib;
    nib = $urandom_range(0, 9);
    if (nib >= 8) nib = $urandom_range(8, 15);
    mst_addr[i]  = {4'(nib), 28'($urandom)};
    mst_we[i]    = 1'($urandom);
    mst_wdata[i] = $urandom;
  endtask

  // One transaction from the IDLE cycle (cycle 0) through the response cycle exp_cyc.
  // The target slave raises ready in its (wt+1)th request cycle and shows srd only then.
  task automatic run_txn(input string name, input logic [NM-1:0] pend, input int g, input int wt,
                         input logic [31:0] srd, input int exp_cyc, input logic exp_err,
                         input logic [31:0] exp_rd, input bit drop);
    int            sel;
    bit            mapped, acc;
    logic [NM-1:0] cur_req;
    sel    = int'(mst_addr[g][AW-1 -: 4]);
    mapped = sel < NS;
    @(posedge clk); #1;
    m_req_i = pend;
    drive_masters();
    noise_slaves();
    @(negedge clk);
    check({name, ".c0_ready"}, m_ready_o, 0);
    check({name, ".c0_s_req"}, s_req_o, 0);
    check({name, ".c0_rdata"}, m_rdata_o, 0);
    check({name, ".c0_hold"}, hold_flag_o, |(pend & HOLD));
    for (int c = 1; c <= exp_cyc; c++) begin
      @(posedge clk); #1;
      cur_req = drop ? (pend & ~(4'(1) << g)) : pend;
      m_req_i = cur_req;
      scramble_masters();
      noise_slaves();
      if (mapped) begin
        s_ready_i[sel] = (c > wt);
        if (c == wt + 1) s_rdata_i[sel] = srd;
      end
      @(negedge clk);
      acc = mapped && (c < exp_cyc);
      check({name, ".s_req"}, s_req_o, acc ? (8'd1 << sel) : 8'd0);
      check({name, ".s_addr"}, s_addr_o, acc ? mst_addr[g] : 32'd0);
      check({name, ".s_we"}, s_we_o, acc ? mst_we[g] : 1'b0);
      check({name, ".s_wdata"}, s_wdata_o, acc ? mst_wdata[g] : 32'd0);
      check({name, ".m_ready"}, m_ready_o, (c == exp_cyc) ? (4'd1 << g) : 4'd0);
      check({name, ".m_rdata"}, m_rdata_o, (c == exp_cyc) ? exp_rd : 32'd0);
      if (c == exp_cyc) check({name, ".m_err"}, m_err_o, exp_err);
      check({name, ".hold"}, hold_flag_o, (|(cur_req & HOLD)) | HOLD[g]);
    end
  endtask

  // Reference model: pending masters persist until served; round-robin search from ptr_m;
  // latency 2 + wait, capped at TIMEOUT + 2 with an error; unmapped answers at cycle 2.
  task automatic random_phase(input int n);
    logic [NM-1:0] pend, fresh;
    int            g, wt, cyc;
    bit            mapped, err;
    logic [31:0]   srd;
    pend = '0;
    for (int t = 0; t < n; t++) begin
      fresh = 4'($urandom);
      for (int i = 0; i < NM; i++)
        if (fresh[i] && !pend[i]) begin
          new_master(i);
          pend[i] = 1'b1;
        end
      if (pend == '0) begin
        g = $urandom_range(0, NM - 1);
        new_master(g);
        pend[g] = 1'b1;
      end
      g = -1;
      for (int k = 0; k < NM; k++)
        if (g < 0 && pend[(ptr_m + k) % NM]) g = (ptr_m + k) % NM;
      wt     = $urandom_range(0, 6);
      mapped = mst_addr[g][31:28] < NS;
      srd    = $urandom;
      err    = !mapped || (wt > TO);
      cyc    = !mapped ? 2 : ((wt <= TO) ? wt + 2 : TO + 2);
      run_txn($sformatf("rnd%0d", t), pend, g, wt, srd, cyc, err, err ? 32'd0 : srd,
              $urandom_range(0, 3) == 0);
      pend[g] = 1'b0;
      ptr_m   = (g + 1) % NM;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected $finish");
    $fatal(1);
  end

  initial begin
    int fp_m0;
    vecs[0] = '{1, 32'h1000_0040, 1'b0, 32'h0,  0,  32'hDEAD_BEEF, 2, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{3, 32'h6000_0008, 1'b1, 32'h55, 3,  32'h0000_1234, 5, 1'b0, 32'h0000_1234};
    vecs[2] = '{0, 32'h6000_0010, 1'b0, 32'h0,  10, 32'hCAFE_F00D, 6, 1'b1, 32'h0};
    vecs[3] = '{2, 32'hF000_0000, 1'b0, 32'h0,  0,  32'h1111_1111, 2, 1'b1, 32'h0};
    vecs[4] = '{0, 32'h7FFF_FFFC, 1'b0, 32'h0,  4,  32'hA5A5_5A5A, 6, 1'b0, 32'hA5A5_5A5A};
    vecs[5] = '{3, 32'h8000_0000, 1'b1, 32'h77, 0,  32'h2222_2222, 2, 1'b1, 32'h0};
    vecs[6] = '{1, 32'h0000_0000, 1'b0, 32'h0,  5,  32'h3333_3333, 6, 1'b1, 32'h0};

    for (int i = 0; i < NM; i++) begin
      mst_addr[i] = '0; mst_we[i] = 1'b0; mst_wdata[i] = '0;
    end
    rst_n = 1'b0;
    fp_req = '0;
    drive_masters();
    noise_slaves();
    m_req_i = 4'b1111;
    repeat (2) @(negedge clk);
    check("reset.m_ready", m_ready_o, 0);
    check("reset.s_req", s_req_o, 0);
    check("reset.m_rdata", m_rdata_o, 0);
    check("reset.m_err", m_err_o, 0);
    check("reset.s_addr", s_addr_o, 0);
    check("reset.hold", hold_flag_o, 0);
    check("reset.fp_hold", fp_hold, 0);
    m_req_i = '0;
    #2 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      mst_addr[vecs[i].mst]  = vecs[i].addr;
      mst_we[vecs[i].mst]    = vecs[i].we;
      mst_wdata[vecs[i].mst] = vecs[i].wdata;
      run_txn($sformatf("vec%0d", i), 4'(1) << vecs[i].mst, vecs[i].mst, vecs[i].wt,
              vecs[i].srd, vecs[i].exp_cyc, vecs[i].exp_err, vecs[i].exp_rd, 1'b0);
      ptr_m = (vecs[i].mst + 1) % NM;
    end

    random_phase(150);

    // Reset asserted mid-ACCESS aborts the transfer without a ready pulse.
    @(posedge clk); #1;
    m_req_i = '0;
    @(posedge clk); #1;
    mst_addr[2] = 32'h6000_0000;
    mst_we[2]   = 1'b1;
    drive_masters();
    m_req_i   = 4'b0100;
    s_ready_i = '0;
    @(posedge clk); #1;
    s_ready_i = '0;
    @(negedge clk);
    check("rst_mid.access_s_req", s_req_o, 8'b0100_0000);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.s_req", s_req_o, 0);
    check("rst_mid.s_we", s_we_o, 0);
    check("rst_mid.s_addr", s_addr_o, 0);
    check("rst_mid.s_wdata", s_wdata_o, 0);
    check("rst_mid.m_ready", m_ready_o, 0);
    check("rst_mid.m_rdata", m_rdata_o, 0);
    check("rst_mid.m_err", m_err_o, 0);
    check("rst_mid.hold", hold_flag_o, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_mid.no_ready", m_ready_o, 0);
    end
    m_req_i = '0;
    for (int i = 0; i < NM; i++) begin
      mst_addr[i] = 32'h1000_0000 + 32'(i * 4); mst_we[i] = 1'b0;
    end
    #2 rst_n = 1'b1;

    // All masters request continuously: grants go 0,1,2,3,0 on 3-cycle slots.
    for (int k = 0; k < 5; k++) begin
      logic [31:0] srd;
      srd = $urandom;
      run_txn($sformatf("rr%0d", k), 4'b1111, k % NM, 0, srd, 2, 1'b0, srd, 1'b0);
    end

    // Fixed priority: m0 and m3 both request; only m0 is ever served.
    @(posedge clk); #1;
    m_req_i     = '0;
    mst_addr[0] = 32'h1000_0000;
    mst_addr[3] = 32'h2000_0000;
    drive_masters();
    s_ready_i = '1;
    fp_req    = 4'b1001;
    fp_m0     = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("fp.only_m0", fp_ready & 4'b1110, 0);
      if (fp_ready[0]) fp_m0++;
    end
    check("fp.m0_pulses", fp_m0, 4);
    fp_req = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
